// File: rtl/mmt_trace_engine.sv
// Matrix-multiply/transpose trace engine: loads a bank of square matrices and
// returns trace(opA(A)*opB(B)*opC(C)) for a 3-beat index command.
module mmt_mac_lane #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 30
) (
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [OUT_W-1:0]  prod
);
  logic signed [OUT_W-1:0] ax, bx;

  assign ax   = {{(OUT_W-DATA_W){a[DATA_W-1]}}, a};
  assign bx   = {{(OUT_W-DATA_W){b[DATA_W-1]}}, b};
  assign prod = en ? ax * bx : '0;
endmodule

module mmt_trace_engine #(
  parameter int DATA_W  = 8,
  parameter int NUM_MAT = 8,
  parameter int MAX_DIM = 4,
  parameter int IDX_W   = $clog2(NUM_MAT),
  parameter int OUT_W   = 3*DATA_W + 3*$clog2(MAX_DIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [1:0]              matrix_size,
  input  logic signed [DATA_W-1:0] matrix,
  input  logic                    in_valid2,
  input  logic [2:0]              mode,
  input  logic [IDX_W-1:0]        matrix_idx,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_value
);
  localparam int DIM_W = $clog2(MAX_DIM);
  localparam int SZ_W  = DIM_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_GETIDX = 3'd2;
  localparam logic [2:0] S_CALC   = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  typedef struct packed {
    logic [2:0]       mode;
    logic [IDX_W-1:0] a;
    logic [IDX_W-1:0] b;
    logic [IDX_W-1:0] c;
  } cmd_t;

  logic [2:0]              state;
  logic [1:0]              size_code;
  logic [IDX_W-1:0]        mat;
  logic [DIM_W-1:0]        row, col, ci, cj;
  logic [1:0]              beat;
  cmd_t                    cmd;
  logic signed [OUT_W-1:0] acc;
  logic [NUM_MAT-1:0][MAX_DIM-1:0][MAX_DIM-1:0][DATA_W-1:0] bank;

  // Effective dimension: 2<<code, clamped to what the bank can hold
  logic [5:0]      size_raw;
  logic [SZ_W-1:0] size, size_m1;
  assign size_raw = 6'd2 << size_code;
  assign size     = (size_raw > 6'(MAX_DIM)) ? SZ_W'(MAX_DIM) : size_raw[SZ_W-1:0];
  assign size_m1  = size - SZ_W'(1);

  logic last_col, last_row, last_mat, last_j, last_i;
  assign last_col = SZ_W'(col) == size_m1;
  assign last_row = SZ_W'(row) == size_m1;
  assign last_mat = mat == IDX_W'(NUM_MAT-1);
  assign last_j   = SZ_W'(cj) == size_m1;
  assign last_i   = SZ_W'(ci) == size_m1;

  // Transposition is a swap of row/col at read time
  logic [MAX_DIM-1:0][DATA_W-1:0] lane_a, lane_b;
  logic [MAX_DIM-1:0][OUT_W-1:0]  lane_p;

  for (genvar k = 0; k < MAX_DIM; k++) begin : g_lane
    localparam logic [DIM_W-1:0] K = DIM_W'(k);
    assign lane_a[k] = cmd.mode[0] ? bank[cmd.a][K][ci] : bank[cmd.a][ci][K];
    assign lane_b[k] = cmd.mode[1] ? bank[cmd.b][cj][K] : bank[cmd.b][K][cj];
    mmt_mac_lane #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_lane (
      .en   (SZ_W'(k) < size),
      .a    (lane_a[k]),
      .b    (lane_b[k]),
      .prod (lane_p[k])
    );
  end

  logic [DATA_W-1:0]       c_elem;
  logic [OUT_W-1:0]        ksum;
  logic signed [OUT_W-1:0] c_ext, term;

  assign c_elem = cmd.mode[2] ? bank[cmd.c][ci][cj] : bank[cmd.c][cj][ci];
  assign c_ext  = {{(OUT_W-DATA_W){c_elem[DATA_W-1]}}, c_elem};

  always_comb begin
    ksum = '0;
    for (int k = 0; k < MAX_DIM; k++) ksum = ksum + lane_p[k];
  end

  assign term = $signed(ksum) * c_ext;
  assign busy = (state == S_CALC) || (state == S_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      size_code <= '0;
      mat       <= '0;
      row       <= '0;
      col       <= '0;
      ci        <= '0;
      cj        <= '0;
      beat      <= '0;
      cmd       <= '0;
      acc       <= '0;
      bank      <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
    end else begin
      out_valid <= 1'b0;
      out_value <= '0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            size_code     <= matrix_size;
            bank[0][0][0] <= matrix;
            mat           <= '0;
            row           <= '0;
            col           <= DIM_W'(1);
            state         <= S_LOAD;
          end else if (in_valid2) begin
            cmd.mode <= mode;
            cmd.a    <= matrix_idx;
            beat     <= 2'd1;
            state    <= S_GETIDX;
          end
        end
        S_LOAD: begin
          if (!in_valid) begin
            state <= S_IDLE;
          end else begin
            bank[mat][row][col] <= matrix;
            if (!last_col) begin
              col <= col + DIM_W'(1);
            end else begin
              col <= '0;
              if (!last_row) begin
                row <= row + DIM_W'(1);
              end else begin
                row <= '0;
                if (last_mat) begin
                  mat   <= '0;
                  state <= S_IDLE;
                end else begin
                  mat <= mat + IDX_W'(1);
                end
              end
            end
          end
        end
        S_GETIDX: begin
          if (!in_valid2) begin
            beat  <= '0;
            state <= S_IDLE;
          end else if (beat == 2'd1) begin
            cmd.b <= matrix_idx;
            beat  <= 2'd2;
          end else begin
            cmd.c <= matrix_idx;
            beat  <= '0;
            acc   <= '0;
            ci    <= '0;
            cj    <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc + term;
          if (!last_j) begin
            cj <= cj + DIM_W'(1);
          end else begin
            cj <= '0;
            if (last_i) begin
              ci    <= '0;
              state <= S_OUT;
            end else begin
              ci <= ci + DIM_W'(1);
            end
          end
        end
        S_OUT: begin
          out_valid <= 1'b1;
          out_value <= acc;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmt_trace_engine.sv
// Directed + randomized bench for mmt_trace_engine; results are checked against
// a matrix-product-and-trace reference model held in the bench.
module tb_mmt_trace_engine;
  localparam int DATA_W  = 8;
  localparam int NUM_MAT = 8;
  localparam int MAX_DIM = 4;
  localparam int IDX_W   = 3;
  localparam int OUT_W   = 30;

  logic                    clk = 1'b0;
  logic                    rst, in_valid, in_valid2;
  logic [1:0]              matrix_size;
  logic signed [DATA_W-1:0] matrix;
  logic [2:0]              mode;
  logic [IDX_W-1:0]        matrix_idx;
  logic                    busy, out_valid;
  logic signed [OUT_W-1:0] out_value;

  mmt_trace_engine #(.DATA_W(DATA_W), .NUM_MAT(NUM_MAT), .MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .matrix_size(matrix_size), .matrix(matrix),
    .in_valid2(in_valid2), .mode(mode), .matrix_idx(matrix_idx),
    .busy(busy), .out_valid(out_valid), .out_value(out_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mdl [NUM_MAT][MAX_DIM][MAX_DIM];
  int cur_code = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int msize(input int code);
    int s;
    s = 2 << code;
    return (s > MAX_DIM) ? MAX_DIM : s;
  endfunction

  // trace(opA(A) * opB(B) * opC(C)) by explicit matrix products
  function automatic longint ref_trace(input int md, input int ia, input int ib, input int ic);
    longint a[MAX_DIM][MAX_DIM], b[MAX_DIM][MAX_DIM], c[MAX_DIM][MAX_DIM];
    longint p[MAX_DIM][MAX_DIM], q[MAX_DIM][MAX_DIM];
    longint tr;
    int n;
    n = msize(cur_code);
    for (int r = 0; r < n; r++)
      for (int s = 0; s < n; s++) begin
        a[r][s] = md[0] ? mdl[ia][s][r] : mdl[ia][r][s];
        b[r][s] = md[1] ? mdl[ib][s][r] : mdl[ib][r][s];
        c[r][s] = md[2] ? mdl[ic][s][r] : mdl[ic][r][s];
      end
    for (int r = 0; r < n; r++)
      for (int s = 0; s < n; s++) begin
        p[r][s] = 0;
        for (int t = 0; t < n; t++) p[r][s] += a[r][t] * b[t][s];
      end
    for (int r = 0; r < n; r++)
      for (int s = 0; s < n; s++) begin
        q[r][s] = 0;
        for (int t = 0; t < n; t++) q[r][s] += p[r][t] * c[t][s];
      end
    tr = 0;
    for (int r = 0; r < n; r++) tr += q[r][r];
    return tr;
  endfunction

  // Stream n_beats elements; rnd=1 draws fresh random data into the model,
  // otherwise the preset model contents are sent.
  task automatic load(input int code, input int n_beats, input bit rnd, input bit stray2);
    int n, m, r, c, e, pulses;
    n = msize(code);
    pulses = 0;
    for (int bt = 0; bt < n_beats; bt++) begin
      m = bt / (n*n);
      r = (bt / n) % n;
      c = bt % n;
      if (rnd) mdl[m][r][c] = int'($urandom_range(0, 255)) - 128;
      e = mdl[m][r][c];
      in_valid    = 1'b1;
      matrix_size = (bt == 0) ? 2'(code) : 2'($urandom);
      matrix      = 8'(e);
      in_valid2   = stray2 && (bt == 0);
      mode        = 3'($urandom);
      matrix_idx  = IDX_W'($urandom);
      step();
      if (out_valid) pulses++;
    end
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    cur_code  = code;
    step();
    if (out_valid) pulses++;
    check("load_no_pulse", pulses, 0);
  endtask

  task automatic run_cmd(input string tag, input int md, input int ia, input int ib, input int ic,
                         input logic signed [63:0] exp, input int stray);
    int n, lat;
    n = msize(cur_code);
    in_valid2 = 1'b1; mode = 3'(md); matrix_idx = IDX_W'(ia);
    step();
    mode = 3'($urandom); matrix_idx = IDX_W'(ib);
    step();
    matrix_idx = IDX_W'(ic);
    step();
    check({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid2  = (lat < stray);
      matrix_idx = IDX_W'($urandom);
      step();
      lat++;
    end
    in_valid2 = 1'b0;
    check({tag, "_lat"}, lat, n*n + 1);
    check({tag, "_val"}, out_value, exp);
    step();
    check({tag, "_vld_drop"}, out_valid, 0);
    check({tag, "_val_zero"}, out_value, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int pulses, ia, ib, ic, md, code, nb;
    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; matrix_size = '0; matrix = '0;
    mode = '0; matrix_idx = '0;
    for (int m = 0; m < NUM_MAT; m++)
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++) mdl[m][r][c] = 0;
    step(); step(); step();
    check("rst_vld", out_valid, 0);
    check("rst_val", out_value, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    run_cmd("empty", 0, 0, 1, 2, 0, 0);

    // Directed 2x2 bank
    for (int m = 0; m < NUM_MAT; m++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) mdl[m][r][c] = (r == c) ? 1 : 0;
    mdl[0][0][0] = 1; mdl[0][0][1] = 2; mdl[0][1][0] = 3; mdl[0][1][1] = 4;
    mdl[1][0][0] = 0; mdl[1][0][1] = 1; mdl[1][1][0] = 0; mdl[1][1][1] = 0;
    load(0, NUM_MAT*4, 1'b0, 1'b0);
    run_cmd("dir_m0", 0, 0, 1, 2, 3, 0);
    run_cmd("dir_m2", 2, 0, 1, 2, 2, 0);

    // Full-scale negative
    for (int m = 0; m < NUM_MAT; m++)
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++) mdl[m][r][c] = -128;
    load(1, NUM_MAT*16, 1'b0, 1'b0);
    run_cmd("fullscale", 7, 5, 5, 5, -134217728, 0);

    // Size code clamp
    for (int m = 0; m < NUM_MAT; m++)
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++) mdl[m][r][c] = 1;
    load(3, NUM_MAT*16, 1'b0, 1'b0);
    run_cmd("clamp", 0, 0, 1, 2, 64, 0);

    // in_valid and in_valid2 together in IDLE, then stray in_valid2 during CALC
    load(1, NUM_MAT*16, 1'b1, 1'b1);
    run_cmd("stray", 5, 3, 6, 1, ref_trace(5, 3, 6, 1), 3);
    pulses = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (out_valid) pulses++;
    end
    check("stray_one_pulse", pulses, 0);

    // Reset on the third CALC cycle
    in_valid2 = 1'b1; mode = 3'd0; matrix_idx = 3'd0;
    step();
    matrix_idx = 3'd1;
    step();
    matrix_idx = 3'd2;
    step();
    in_valid2 = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    pulses = 0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (out_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    for (int m = 0; m < NUM_MAT; m++)
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++) mdl[m][r][c] = 0;
    cur_code = 0;
    run_cmd("post_rst_clear", 0, 3, 4, 5, 0, 0);
    load(1, NUM_MAT*16, 1'b1, 1'b0);
    run_cmd("reload", 1, 2, 7, 4, ref_trace(1, 2, 7, 4), 0);

    // Random loads (some cut short) and commands
    for (int it = 0; it < 8; it++) begin
      code = $urandom_range(0, 3);
      nb   = NUM_MAT * msize(code) * msize(code);
      if (it % 3 == 2) nb = $urandom_range(1, nb - 1);
      load(code, nb, 1'b1, 1'b0);
      for (int q = 0; q < 2; q++) begin
        md = $urandom_range(0, 7);
        ia = $urandom_range(0, NUM_MAT-1);
        ib = $urandom_range(0, NUM_MAT-1);
        ic = (q == 1) ? ia : $urandom_range(0, NUM_MAT-1);
        run_cmd("rand", md, ia, ib, ic, ref_trace(md, ia, ib, ic), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
